// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, variable-latency data memory.
// One transaction at a time: IDLE grants, BUSY waits for M_Ready or timeout, DONE acks.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        P_Req,
  input  logic        P_Write,
  input  logic [31:0] P_Addr,
  input  logic [31:0] P_WData,
  output logic [31:0] P_RData,
  output logic        P_Ack,
  output logic        P_Err,
  output logic        P_Stall,
  input  logic        L_Req,
  input  logic        L_Write,
  input  logic [31:0] L_Addr,
  input  logic [31:0] L_WData,
  output logic [31:0] L_RData,
  output logic        L_Ack,
  output logic        L_Err,
  output logic        M_En,
  output logic        M_Write,
  output logic [31:0] M_Addr,
  output logic [31:0] M_WData,
  input  logic [31:0] M_RData,
  input  logic        M_Ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {GRANT_P, GRANT_L} port_e;

  state_e      state, next_state;
  port_e       grant, last_grant, next_grant;
  logic [7:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic        err_flag;
  logic [31:0] p_rdata_q, l_rdata_q;
  logic        timeout_hit;

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    next_grant = grant;
    case (state)
      IDLE: begin
        if (P_Req || L_Req) begin
          next_state = BUSY;
          if (P_Req && L_Req) next_grant = (last_grant == GRANT_P) ? GRANT_L : GRANT_P;
          else                next_grant = P_Req ? GRANT_P : GRANT_L;
        end
      end
      BUSY:    if (M_Ready || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A ready in the timeout cycle wins: success is tested before the abort path.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      grant      <= GRANT_P;
      last_grant <= GRANT_L;
      wait_cnt   <= 8'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      err_flag   <= 1'b0;
      p_rdata_q  <= 32'h0;
      l_rdata_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (next_state == BUSY) begin
            grant     <= next_grant;
            wait_cnt  <= 8'd0;
            err_flag  <= 1'b0;
            lat_write <= (next_grant == GRANT_P) ? P_Write : L_Write;
            lat_addr  <= (next_grant == GRANT_P) ? P_Addr  : L_Addr;
            lat_wdata <= (next_grant == GRANT_P) ? P_WData : L_WData;
          end
        end
        BUSY: begin
          if (M_Ready) begin
            if (!lat_write) begin
              if (grant == GRANT_P) p_rdata_q <= M_RData;
              else                  l_rdata_q <= M_RData;
            end
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
            if (grant == GRANT_P) p_rdata_q <= 32'h0;
            else                  l_rdata_q <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    last_grant <= grant;
        default: ;
      endcase
    end
  end

  // Requester outputs decode registered state only; no M_* input reaches them within a cycle.
  always_comb begin
    M_En    = 1'b0;
    M_Write = 1'b0;
    P_Ack   = 1'b0;
    L_Ack   = 1'b0;
    P_Err   = 1'b0;
    L_Err   = 1'b0;
    case (state)
      BUSY: begin
        M_En    = 1'b1;
        M_Write = lat_write;
      end
      DONE: begin
        P_Ack = (grant == GRANT_P);
        L_Ack = (grant == GRANT_L);
        P_Err = (grant == GRANT_P) && err_flag;
        L_Err = (grant == GRANT_L) && err_flag;
      end
      default: ;
    endcase
  end

  assign M_Addr  = lat_addr;
  assign M_WData = lat_wdata;
  assign P_RData = p_rdata_q;
  assign L_RData = l_rdata_q;
  assign P_Stall = P_Req & ~P_Ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=4) with a scoreboard of expected acks.
module tb_mem_bus_arbiter;

  logic        Clk, Reset;
  logic        P_Req, P_Write, L_Req, L_Write, M_Ready;
  logic [31:0] P_Addr, P_WData, L_Addr, L_WData, M_RData;
  logic [31:0] P_RData, L_RData, M_Addr, M_WData;
  logic        P_Ack, P_Err, P_Stall, L_Ack, L_Err, M_En, M_Write;

  typedef struct {
    logic        is_l;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_writes = 0;
  int   writes_before;

  mem_bus_arbiter #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .P_Req(P_Req), .P_Write(P_Write), .P_Addr(P_Addr), .P_WData(P_WData),
    .P_RData(P_RData), .P_Ack(P_Ack), .P_Err(P_Err), .P_Stall(P_Stall),
    .L_Req(L_Req), .L_Write(L_Write), .L_Addr(L_Addr), .L_WData(L_WData),
    .L_RData(L_RData), .L_Ack(L_Ack), .L_Err(L_Err),
    .M_En(M_En), .M_Write(M_Write), .M_Addr(M_Addr), .M_WData(M_WData),
    .M_RData(M_RData), .M_Ready(M_Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic is_l, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.is_l = is_l; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every ack must match the oldest expected response.
  always @(negedge Clk) begin
    exp_t e;
    if (P_Ack || L_Ack) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ack_port", {31'd0, L_Ack}, {31'd0, e.is_l});
        check("ack_both", {31'd0, P_Ack & L_Ack}, 32'd0);
        check("ack_rdata", L_Ack ? L_RData : P_RData, e.rdata);
        check("ack_err", {31'd0, L_Ack ? L_Err : P_Err}, {31'd0, e.err});
      end
    end
    if (M_En && M_Write && M_Ready) n_writes++;
  end

  initial begin
    Reset = 1'b0; M_Ready = 1'b0; M_RData = 32'h0;
    P_Req = 1'b0; P_Write = 1'b0; P_Addr = 32'h0; P_WData = 32'h0;
    L_Req = 1'b0; L_Write = 1'b0; L_Addr = 32'h0; L_WData = 32'h0;
    tick(); tick();
    check("rst_m_en", {31'd0, M_En}, 32'd0);
    check("rst_m_write", {31'd0, M_Write}, 32'd0);
    check("rst_acks", {30'd0, P_Ack, L_Ack}, 32'd0);
    check("rst_m_addr", M_Addr, 32'h0);
    check("rst_p_rdata", P_RData, 32'h0);
    check("rst_l_rdata", L_RData, 32'h0);
    #2 Reset = 1'b1;

    // Single P load, ready at cycle 3
    tick();
    P_Req = 1'b1; P_Write = 1'b0; P_Addr = 32'h40;
    push(1'b0, 32'h1234ABCD, 1'b0);
    #1 check("t1_stall_c0", {31'd0, P_Stall}, 32'd1);
    check("t1_men_c0", {31'd0, M_En}, 32'd0);
    tick();
    check("t1_men_c1", {31'd0, M_En}, 32'd1);
    check("t1_addr_c1", M_Addr, 32'h40);
    check("t1_stall_c1", {31'd0, P_Stall}, 32'd1);
    P_Addr = 32'hDEAD0000;
    tick();
    check("t1_men_c2", {31'd0, M_En}, 32'd1);
    check("t1_addr_stable", M_Addr, 32'h40);
    tick();
    check("t1_men_c3", {31'd0, M_En}, 32'd1);
    M_Ready = 1'b1; M_RData = 32'h1234ABCD;
    #1 check("t1_stall_c3", {31'd0, P_Stall}, 32'd1);
    tick();
    M_Ready = 1'b0;
    check("t1_ack_c4", {31'd0, P_Ack}, 32'd1);
    check("t1_rdata_c4", P_RData, 32'h1234ABCD);
    check("t1_stall_c4", {31'd0, P_Stall}, 32'd0);
    check("t1_men_c4", {31'd0, M_En}, 32'd0);
    P_Req = 1'b0;
    tick();
    check("t1_idle_ack", {31'd0, P_Ack}, 32'd0);
    // M_Ready pulsed while IDLE is ignored
    M_Ready = 1'b1; M_RData = 32'hBAD0BAD0;
    tick();
    M_Ready = 1'b0;
    check("t6_idle_men", {31'd0, M_En}, 32'd0);
    check("t6_idle_rdata", P_RData, 32'h1234ABCD);
    tick();

    // Simultaneous requests after reset: P wins first tie
    Reset = 1'b0; tick(); #2 Reset = 1'b1;
    tick();
    P_Req = 1'b1; P_Write = 1'b1; P_Addr = 32'h10; P_WData = 32'hCAFEF00D;
    L_Req = 1'b1; L_Write = 1'b0; L_Addr = 32'h20;
    push(1'b0, 32'h0, 1'b0);
    tick();
    check("t2_p_write", {31'd0, M_Write}, 32'd1);
    check("t2_p_addr", M_Addr, 32'h10);
    check("t2_p_wdata", M_WData, 32'hCAFEF00D);
    check("t2_l_stalled", {31'd0, L_Ack}, 32'd0);
    M_Ready = 1'b1;
    tick();
    M_Ready = 1'b0;
    check("t2_p_ack", {31'd0, P_Ack}, 32'd1);
    P_Req = 1'b0;
    push(1'b1, 32'h55AA55AA, 1'b0);
    tick();
    check("t2_idle_men", {31'd0, M_En}, 32'd0);
    tick();
    check("t2_l_addr", M_Addr, 32'h20);
    check("t2_l_write", {31'd0, M_Write}, 32'd0);
    P_Req = 1'b1; P_Write = 1'b0; P_Addr = 32'h30;
    M_Ready = 1'b1; M_RData = 32'h55AA55AA;
    #1 check("t2_p_stall_busy_l", {31'd0, P_Stall}, 32'd1);
    tick();
    M_Ready = 1'b0;
    check("t2_l_ack", {31'd0, L_Ack}, 32'd1);
    push(1'b0, 32'h00000077, 1'b0);
    tick();
    tick();
    check("t2_tie2_p_addr", M_Addr, 32'h30);
    L_Req = 1'b0;
    M_Ready = 1'b1; M_RData = 32'h00000077;
    tick();
    M_Ready = 1'b0;
    P_Req = 1'b0;
    tick();

    // Back-to-back loader writes, ready in first BUSY cycle, L_Req held high
    writes_before = n_writes;
    L_Req = 1'b1; L_Write = 1'b1; L_Addr = 32'h100; L_WData = 32'hA;
    push(1'b1, 32'h55AA55AA, 1'b0);
    push(1'b1, 32'h55AA55AA, 1'b0);
    tick();
    M_Ready = 1'b1;
    tick();
    check("t3_ack1", {31'd0, L_Ack}, 32'd1);
    check("t3_done_men", {31'd0, M_En}, 32'd0);
    L_Addr = 32'h104; L_WData = 32'hB;
    tick();
    check("t3_idle_noack", {31'd0, L_Ack}, 32'd0);
    check("t3_idle_men", {31'd0, M_En}, 32'd0);
    tick();
    check("t3_busy2_addr", M_Addr, 32'h104);
    check("t3_busy2_wdata", M_WData, 32'hB);
    check("t3_busy2_noack", {31'd0, L_Ack}, 32'd0);
    tick();
    M_Ready = 1'b0;
    check("t3_ack2", {31'd0, L_Ack}, 32'd1);
    check("t3_done2_men", {31'd0, M_En}, 32'd0);
    L_Req = 1'b0;
    tick();
    check("t3_write_count", 32'(n_writes - writes_before), 32'd2);

    // Timeout with M_Ready held low
    P_Req = 1'b1; P_Write = 1'b0; P_Addr = 32'h200;
    push(1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t4_men_busy", {31'd0, M_En}, 32'd1);
    end
    tick();
    check("t4_ack", {31'd0, P_Ack}, 32'd1);
    check("t4_err", {31'd0, P_Err}, 32'd1);
    check("t4_rdata", P_RData, 32'h0);
    check("t4_men_done", {31'd0, M_En}, 32'd0);
    P_Req = 1'b0;
    tick();
    check("t4_idle_men", {31'd0, M_En}, 32'd0);
    check("t4_idle_ack", {31'd0, P_Ack}, 32'd0);

    // Ready in the timeout cycle counts as success
    P_Req = 1'b1; P_Addr = 32'h204;
    push(1'b0, 32'h00000099, 1'b0);
    tick(); tick(); tick(); tick();
    check("t4b_men_last", {31'd0, M_En}, 32'd1);
    M_Ready = 1'b1; M_RData = 32'h00000099;
    tick();
    M_Ready = 1'b0;
    check("t4b_no_err", {31'd0, P_Err}, 32'd0);
    P_Req = 1'b0;
    tick();

    // Reset mid-BUSY: access aborted, no ack, then a clean retry
    P_Req = 1'b1; P_Addr = 32'h300;
    tick(); tick();
    #2 Reset = 1'b0;
    #1 check("t5_men_drop", {31'd0, M_En}, 32'd0);
    check("t5_noack", {31'd0, P_Ack}, 32'd0);
    tick();
    check("t5_rst_addr", M_Addr, 32'h0);
    check("t5_rst_rdata", P_RData, 32'h0);
    #2 Reset = 1'b1;
    tick();
    check("t5_regrant", {31'd0, M_En}, 32'd1);
    check("t5_regrant_addr", M_Addr, 32'h300);
    M_Ready = 1'b1; M_RData = 32'h42424242;
    push(1'b0, 32'h42424242, 1'b0);
    tick();
    M_Ready = 1'b1; M_RData = 32'hFFFF0000;
    check("t5_ack", {31'd0, P_Ack}, 32'd1);
    P_Req = 1'b0;
    // M_Ready held through DONE and the following IDLE is ignored
    tick();
    check("t6_done_ready_rdata", P_RData, 32'h42424242);
    check("t6_done_ready_men", {31'd0, M_En}, 32'd0);
    tick();
    M_Ready = 1'b0;
    check("t6_idle2_ack", {31'd0, P_Ack}, 32'd0);
    tick(); tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
